sc_stream_decoder: RTL and testbench
====================================

Name: sc_stream_decoder

Overview:
Stochastic-to-binary converter. It is the decode end of the stochastic datapath: it consumes a unipolar bitstream, such as the output of the scaling adder or another SC operator, and counts the ones over a fixed window of 2^LOG2_LEN valid samples. It returns the binary estimate of the stream probability through a valid/ready result handshake. It is the counterpart of the SNG, which encodes a binary value into a stream.

Parameters:
LOG2_LEN, 8, log2 of the window length in valid samples (window = 256 samples by default).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse; begins a new accumulation window
bit_in  input  1  stochastic stream bit
bit_valid  input  1  bit_in carries a sample this cycle
busy  output  1  high while a window is accumulating
count_out  output  LOG2_LEN+1  number of ones in the completed window, range 0..2^LOG2_LEN
count_valid  output  1  count_out holds a completed result
count_ready  input  1  downstream accepts the result

Behaviour:
- Three-state FSM:
  - IDLE: busy=0, count_valid=0.
  - ACCUM: busy=1, count_valid=0.
  - HOLD: busy=0, count_valid=1.
- Reset (asynchronous, any state, including mid-window):
  - FSM goes to IDLE.
  - Sample counter and ones counter are cleared.
  - count_out=0, busy=0, count_valid=0.
- IDLE:
  - start=1 goes to ACCUM, with both counters cleared to 0.
  - bit_valid is ignored.
- ACCUM, on each cycle with bit_valid=1:
  - Sample counter increments by 1.
  - Ones counter increments by bit_in.
  - Cycles with bit_valid=0 leave both counters unchanged.
- Window completion:
  - Completion is the cycle that accepts the 2^LOG2_LEN-th valid sample.
  - On that edge, count_out is loaded with the final ones count, including that sample, and the FSM goes to HOLD.
  - count_valid is high from the next cycle.
  - Minimum latency from the start edge to count_valid is 2^LOG2_LEN+1 cycles.
- Counter widths: both counters are LOG2_LEN+1 bits, so overflow is impossible.
  - All-ones window gives count_out = 2^LOG2_LEN.
  - All-zeros window gives 0.
- start during ACCUM: aborts the window. Counters clear and the FSM stays in ACCUM. A sample presented in the same cycle as start is not counted.
- HOLD:
  - count_out and count_valid stay stable until count_ready=1.
  - bit_valid samples are dropped.
  - start without count_ready is ignored.
- Handshake in HOLD:
  - count_ready=1 with start=0 goes to IDLE.
  - count_ready=1 with start=1 goes directly to ACCUM with counters cleared, giving back-to-back windows with no idle cycle.
- count_out retains the last result after the handshake until the next window completes.
- count_out, count_valid and busy are driven directly from registers (no combinational path from inputs).

Decomposition:
- Shared package sc_pkg holds:
  - the state enum typedef (IDLE, ACCUM, HOLD);
  - a default window constant SC_LOG2_LEN = 8, also used by the SNG so encode and decode windows match.
- Single module; no sub-module is needed. The two counters are simple enough to inline.

Test Plan:
All scenarios use LOG2_LEN=4 (16-sample window).
- Reset mid-window: start, feed 10 ones, assert rst for 1 cycle -> busy=0, count_valid=0, count_out=0 immediately (asynchronous); no result appears later.
- Extremes: 16 consecutive valid 0s -> count_out=0. 16 consecutive valid 1s -> count_out=5'b10000 (16). count_valid rises exactly 17 cycles after the start edge.
- Gapped input: alternating 1,0 with bit_valid high every other cycle for 32 cycles, invalid cycles carrying bit_in=1 -> count_out=8, completion after 32 cycles. Proves invalid samples are not counted.
- Backpressure: count_ready held low for 5 cycles after completion while bit_valid=1, bit_in=1 -> count_out stays 7 and valid stays high. Then count_ready=1 together with start=1 -> next cycle busy=1, and the new window counts from 0 with no idle cycle.
- Restart: start, 7 valid ones, start again, then 16 valid samples containing 3 ones -> count_out=3.
- Random stream: LFSR-driven bit_in with p=0.75, 50 windows -> every count_out equals the reference-model count of ones over the same 16 valid samples.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath (SNG encode and
// stream decode use the same default window so their lengths always match).
package sc_pkg;

  localparam int SC_LOG2_LEN = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } sc_state_t;

endpackage

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter: counts the ones over 2^LOG2_LEN valid
// samples and returns the count through a valid/ready result handshake.
//
// state | meaning
// IDLE  | waiting for start; samples ignored
// ACCUM | window open; valid samples counted
// HOLD  | result presented on count_out until count_ready
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int LOG2_LEN = SC_LOG2_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                busy,
  output logic [LOG2_LEN:0]   count_out,
  output logic                count_valid,
  input  logic                count_ready
);

  localparam int CW = LOG2_LEN + 1;
  localparam logic [CW-1:0] LAST_IDX = {1'b0, {LOG2_LEN{1'b1}}};

  sc_state_t         r_state;
  sc_state_t         w_state_nxt;
  logic [CW-1:0]     r_samp_cnt;
  logic [CW-1:0]     r_ones_cnt;
  logic [CW-1:0]     r_count_out;
  logic [CW-1:0]     w_ones_inc;
  logic              r_busy;
  logic              r_count_valid;
  logic              w_clr;
  logic              w_acc;
  logic              w_done;

  assign w_ones_inc = r_ones_cnt + {{LOG2_LEN{1'b0}}, bit_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // A start inside ACCUM restarts the window and drops that cycle's sample.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_acc       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ACCUM;
          w_clr       = 1'b1;
        end
      end
      ACCUM: begin
        if (start) begin
          w_clr = 1'b1;
        end else if (bit_valid) begin
          w_acc = 1'b1;
          if (r_samp_cnt == LAST_IDX) begin
            w_done      = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (count_ready) begin
          if (start) begin
            w_state_nxt = ACCUM;
            w_clr       = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp_cnt <= '0;
      r_ones_cnt <= '0;
    end else if (w_clr) begin
      r_samp_cnt <= '0;
      r_ones_cnt <= '0;
    end else if (w_acc) begin
      r_samp_cnt <= r_samp_cnt + CW'(1);
      r_ones_cnt <= w_ones_inc;
    end
  end

  // Outputs are registered from the next state so no input reaches a port combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count_out   <= '0;
      r_busy        <= 1'b0;
      r_count_valid <= 1'b0;
    end else begin
      if (w_done) r_count_out <= w_ones_inc;
      r_busy        <= (w_state_nxt == ACCUM);
      r_count_valid <= (w_state_nxt == HOLD);
    end
  end

  assign busy        = r_busy;
  assign count_out   = r_count_out;
  assign count_valid = r_count_valid;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder with a 16-sample window.
module tb_sc_stream_decoder;

  localparam int L = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         count_ready = 1'b0;
  logic         busy;
  logic         count_valid;
  logic [L:0]   count_out;

  int total = 0;
  int bad = 0;
  int sb[$];

  typedef struct {
    string       name;
    logic [15:0] pat;
    int          mode;
    int          exp;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] lfsr = 16'hACE1;

  sc_stream_decoder #(.LOG2_LEN(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .busy        (busy),
    .count_out   (count_out),
    .count_valid (count_valid),
    .count_ready (count_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: a result is consumed on the edge where valid and ready meet.
  always @(negedge clk) begin
    if (!rst && count_valid && count_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got count_out=%0d with no expected entry", count_out);
      end else begin
        check("sb_count_out", int'(count_out), sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: back-to-back valid; 1: invalid cycle (bit_in=1) before each sample; 2: random gaps
  task automatic feed(input logic [15:0] pat, input int mode);
    for (int i = 0; i < N; i++) begin
      int gaps;
      gaps = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        bit_valid = 1'b0;
        bit_in    = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
      end
      bit_valid = 1'b1;
      bit_in    = pat[i];
      tick();
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic collect(input string nm);
    int n;
    n = 0;
    while (!count_valid && n < 100) begin
      tick();
      n++;
    end
    check({nm, "_valid"}, int'(count_valid), 1);
    count_ready = 1'b1;
    tick();
    count_ready = 1'b0;
    check({nm, "_idle_after"}, int'(count_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    logic [15:0] pat;
    int ones;

    vecs[0] = '{"all_zero",  16'h0000, 0, 0};
    vecs[1] = '{"all_one",   16'hFFFF, 0, 16};
    vecs[2] = '{"gapped",    16'h5555, 1, 8};
    vecs[3] = '{"three",     16'h0421, 0, 3};
    vecs[4] = '{"half",      16'h00FF, 2, 8};
    vecs[5] = '{"one_last",  16'h8000, 0, 1};

    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(count_valid), 0);
    check("rst_count", int'(count_out), 0);
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      sb.push_back(vecs[v].exp);
      do_start();
      check({vecs[v].name, "_busy"}, int'(busy), 1);
      feed(vecs[v].pat, vecs[v].mode);
      check({vecs[v].name, "_done_now"}, int'(count_valid), 1);
      collect(vecs[v].name);
    end

    // Latency: start edge counts as cycle 1, result visible after cycle 17.
    sb.push_back(16);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!count_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", n, N + 1);
    bit_valid = 1'b0;
    collect("latency");

    // Backpressure, then back-to-back restart through the handshake.
    sb.push_back(7);
    do_start();
    feed(16'h007F, 0);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_count", int'(count_out), 7);
      check("bp_valid", int'(count_valid), 1);
    end
    count_ready = 1'b1;
    start       = 1'b1;
    tick();
    count_ready = 1'b0;
    start       = 1'b0;
    check("b2b_busy", int'(busy), 1);
    check("b2b_valid", int'(count_valid), 0);
    sb.push_back(2);
    feed(16'h0003, 0);
    collect("b2b");

    // Restart mid-window; the sample in the restart cycle is dropped.
    sb.push_back(3);
    do_start();
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(16'h0111, 0);
    collect("restart");

    // Asynchronous reset mid-window (count_out is nonzero beforehand).
    do_start();
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(count_valid), 0);
    check("arst_count", int'(count_out), 0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (count_valid || busy) seen++;
    end
    check("arst_no_result", seen, 0);
    bit_valid = 1'b0;

    // Random p=0.75 streams against a reference ones count.
    for (int w = 0; w < 50; w++) begin
      ones = 0;
      for (int i = 0; i < N; i++) begin
        lfsr   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        pat[i] = lfsr[0] | lfsr[1];
        if (pat[i]) ones++;
      end
      sb.push_back(ones);
      do_start();
      feed(pat, 2);
      collect("rand");
    end

    tick();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
